// File: rtl/mult_pkg.sv
// Shared definitions for the iterative EX-stage multiplier.
// The hazard unit bench also relies on the fixed latency defined here.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } mult_state_e;

  localparam int MUL_STEPS   = 32;
  localparam int MUL_LATENCY = 34;

endpackage

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add 32x32 multiplier (MUL/MULU) with a fixed 34-cycle latency.
// It holds stall_req to the hazard unit from the issue cycle until the product is valid.
//
// state   | meaning
// IDLE    | waiting for start; stall_req follows start & ~abort
// BUSY    | one shift-add step per cycle, 32 steps
// NEG     | conditional negate (identity when result is non-negative)
// DONE    | product valid, done pulse, stall released
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [0:WIDTH-1] op_a,
  input  logic [0:WIDTH-1] op_b,
  input  logic             abort,
  output logic             stall_req,
  output logic             done,
  output logic [0:WIDTH-1] prod_hi,
  output logic [0:WIDTH-1] prod_lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  mult_state_e          state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  // Partial sum enters the top half; the low half fills with finished product bits.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   mcand,
                                                  input logic               mbit);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mbit ? mcand : '0)};
    return {sum, acc[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    prod_d    = prod_q;
    stall_req = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall_req = start & ~abort & ~rst;
        if (start && !abort) begin
          mcand_d  = (is_signed && op_a[0]) ? -op_a : op_a;
          mplier_d = (is_signed && op_b[0]) ? -op_b : op_b;
          sign_d   = is_signed & (op_a[0] ^ op_b[0]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_req = ~abort;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d    = mul_step(acc_q, mcand_q, mplier_q[0]);
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) state_d = ST_NEG;
        end
      end
      ST_NEG: begin
        stall_req = ~abort;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d   = sign_q ? -acc_q : acc_q;
          prod_d  = sign_q ? -acc_q : acc_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign prod_hi = prod_q[2*WIDTH-1:WIDTH];
  assign prod_lo = prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed vector table, abort/reset/back-to-back
// sequences, and random operands against a plain-arithmetic product model.
module tb_mult_unit;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, is_signed, abort;
  logic        stall_req, done;
  logic [0:31] op_a, op_b, prod_hi, prod_lo;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mult_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .abort     (abort),
    .stall_req (stall_req),
    .done      (done),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] p;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full operation from issue cycle 0 through DONE at MUL_LATENCY; start left high.
  task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input logic poke_done, input string nm);
    op_a = a; op_b = b; is_signed = sgn; start = 1'b1; abort = 1'b0;
    for (int c = 0; c <= MUL_LATENCY; c++) begin
      if (c == MUL_LATENCY && poke_done) begin
        op_a = $urandom; op_b = $urandom; is_signed = ~sgn; abort = 1'b1;
      end
      #4;
      chk($sformatf("%s stall c%0d", nm, c), 64'(stall_req), 64'(c < MUL_LATENCY));
      chk($sformatf("%s done c%0d", nm, c), 64'(done), 64'(c == MUL_LATENCY));
      if (c == MUL_LATENCY) chk({nm, " prod"}, {prod_hi, prod_lo}, exp);
      step();
    end
    abort = 1'b0;
  endtask

  task automatic idle_check(input int n, input logic [63:0] prev, input string nm);
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < n; c++) begin
      #4;
      chk($sformatf("%s idle stall %0d", nm, c), 64'(stall_req), 64'd0);
      chk($sformatf("%s idle done %0d", nm, c), 64'(done), 64'd0);
      chk($sformatf("%s idle prod %0d", nm, c), {prod_hi, prod_lo}, prev);
      step();
    end
  endtask

  task automatic abort_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int ab_c, input logic [63:0] prev, input string nm);
    op_a = a; op_b = b; is_signed = sgn; start = 1'b1; abort = 1'b0;
    for (int c = 0; c <= ab_c; c++) begin
      if (c == ab_c) abort = 1'b1;
      #4;
      chk($sformatf("%s stall c%0d", nm, c), 64'(stall_req), 64'(c < ab_c));
      chk($sformatf("%s done c%0d", nm, c), 64'(done), 64'd0);
      step();
    end
    idle_check(40, prev, nm);
  endtask

  logic [31:0] ra, rb;
  logic        rs;
  logic [31:0] edge_vals[5];

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; abort = 1'b0; op_a = '0; op_b = '0;
    edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'h0000_0001; edge_vals[2] = 32'h8000_0000;
    edge_vals[3] = 32'h7FFF_FFFF; edge_vals[4] = 32'hFFFF_FFFF;

    tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    tbl[1] = '{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
    tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    tbl[3] = '{32'h0000_0002, 32'h0000_0003, 1'b1, 64'h0000_0000_0000_0006};
    tbl[4] = '{32'h0000_0005, 32'h0000_0000, 1'b0, 64'h0000_0000_0000_0000};
    tbl[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000};
    tbl[6] = '{32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000};
    tbl[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};
    tbl[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
    tbl[9] = '{32'h0000_0000, 32'h8000_0000, 1'b1, 64'h0000_0000_0000_0000};

    #2;
    chk("reset stall", 64'(stall_req), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset prod", {prod_hi, prod_lo}, 64'd0);
    start = 1'b1;
    #1;
    chk("reset stall with start", 64'(stall_req), 64'd0);
    start = 1'b0;
    step();
    rst = 1'b0;
    idle_check(2, 64'd0, "post reset");

    for (int i = 0; i < 10; i++) begin
      mul_op(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].p, 1'b0, $sformatf("tbl%0d", i));
      idle_check(1, tbl[i].p, $sformatf("tbl%0d", i));
    end

    mul_op(32'd2, 32'd3, 1'b1, 64'd6, 1'b0, "b2b first");
    mul_op(32'd5, 32'd0, 1'b0, 64'd0, 1'b0, "b2b second");
    idle_check(2, 64'd0, "b2b");

    mul_op(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "pre abort");
    abort_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 10, 64'hFFFF_FFFF_FFFF_FFEB, "abort c10");
    abort_op(32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 33, 64'hFFFF_FFFF_FFFF_FFEB, "abort neg");
    abort_op(32'h0000_0009, 32'h0000_0009, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFEB, "abort c1");

    mul_op(32'h0000_1234, 32'h0000_0010, 1'b0, 64'h0001_2340, 1'b1, "start in done");
    idle_check(3, 64'h0001_2340, "start in done");

    op_a = 32'hDEAD_BEEF; op_b = 32'h0000_0100; is_signed = 1'b0; start = 1'b1;
    for (int c = 0; c < 15; c++) begin
      #4;
      chk($sformatf("pre rst stall c%0d", c), 64'(stall_req), 64'd1);
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async rst stall", 64'(stall_req), 64'd0);
    chk("async rst done", 64'(done), 64'd0);
    chk("async rst prod", {prod_hi, prod_lo}, 64'd0);
    start = 1'b0;
    step();
    rst = 1'b0;
    idle_check(2, 64'd0, "after rst");
    mul_op(32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 64'h0000_00DE_ADBE_EF00, 1'b0, "fresh after rst");
    idle_check(1, 64'h0000_00DE_ADBE_EF00, "fresh after rst");

    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : 32'($urandom);
      rs = 1'($urandom_range(0, 1));
      mul_op(ra, rb, rs, ref_prod(ra, rb, rs), 1'b0, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) idle_check(1, ref_prod(ra, rb, rs), $sformatf("rnd%0d", i));
    end
    idle_check(1, ref_prod(ra, rb, rs), "final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
